// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory responder (slave).
// One request is accepted over valid/ready, then one single-cycle response pulse comes back.
interface data_mem_responder_if;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [1:0]  reqWidth;
  logic        reqUnsigned;
  logic [31:0] reqAddr;
  logic [31:0] reqWData;
  logic        rspValid;
  logic [31:0] rspData;
  logic        rspError;

  modport master (
    output reqValid, reqWrite, reqWidth, reqUnsigned, reqAddr, reqWData,
    input  reqReady, rspValid, rspData, rspError
  );

  modport slave (
    input  reqValid, reqWrite, reqWidth, reqUnsigned, reqAddr, reqWData,
    output reqReady, rspValid, rspData, rspError
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request at a time, LATENCY wait cycles, then a single-cycle response.
// Byte/half/word stores use lane steering; loads are sign- or zero-extended.
//
// state | meaning
// IDLE  | reqReady=1, accept and latch a request
// WAIT  | count down LATENCY, then perform the access and register the response
// RESP  | rspValid=1 for one cycle, then back to IDLE
module data_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input logic           clk,
  input logic           rstN,
  data_mem_responder_if.slave bus
);
  localparam int IDX_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  localparam logic [1:0] MEM_NONE = 2'd0;
  localparam logic [1:0] MEM_BYTE = 2'd1;
  localparam logic [1:0] MEM_HALF = 2'd2;
  localparam logic [1:0] MEM_WORD = 2'd3;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic               write_q, uns_q, err_q;
  logic [1:0]         width_q, lane_q;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        wdata_q;
  logic [31:0]        mem [DEPTH];

  logic               accept, access, req_err;
  logic [3:0]         be;
  logic [31:0]        wlanes, word, load_val;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;

  always_comb begin
    req_err = 1'b0;
    if (bus.reqWidth == MEM_NONE)                            req_err = 1'b1;
    if (bus.reqWidth == MEM_HALF && bus.reqAddr[0])          req_err = 1'b1;
    if (bus.reqWidth == MEM_WORD && bus.reqAddr[1:0] != 2'b0) req_err = 1'b1;
    if (bus.reqAddr[31:2] >= 30'(DEPTH))                     req_err = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstN) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    access     = 1'b0;
    case (state)
      IDLE: if (bus.reqValid) begin
        accept     = 1'b1;
        state_next = WAIT;
      end
      WAIT: if (cnt == '0) begin
        access     = 1'b1;
        state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.reqReady = (state == IDLE);
  assign bus.rspValid = (state == RESP);

  always_comb begin
    be     = 4'b0000;
    wlanes = wdata_q;
    case (width_q)
      MEM_BYTE: begin
        be     = 4'b0001 << lane_q;
        wlanes = {4{wdata_q[7:0]}};
      end
      MEM_HALF: begin
        be     = lane_q[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{wdata_q[15:0]}};
      end
      MEM_WORD: be = 4'b1111;
      default:  be = 4'b0000;
    endcase
  end

  always_comb begin
    word     = mem[idx_q];
    byte_sel = word[8*lane_q +: 8];
    half_sel = lane_q[1] ? word[31:16] : word[15:0];
    case (width_q)
      MEM_BYTE: load_val = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      MEM_HALF: load_val = {{16{~uns_q & half_sel[15]}}, half_sel};
      MEM_WORD: load_val = word;
      default:  load_val = 32'h0;
    endcase
  end

  // Gated by rstN so a store interrupted by reset never lands in the array.
  always_ff @(posedge clk) begin
    if (rstN && access && !err_q && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx_q][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      cnt          <= '0;
      bus.rspData  <= 32'h0;
      bus.rspError <= 1'b0;
    end else begin
      if (accept) begin
        write_q <= bus.reqWrite;
        width_q <= bus.reqWidth;
        uns_q   <= bus.reqUnsigned;
        lane_q  <= bus.reqAddr[1:0];
        idx_q   <= bus.reqAddr[IDX_W+1:2];
        wdata_q <= bus.reqWData;
        err_q   <= req_err;
        cnt     <= CNT_W'(LATENCY);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (access) begin
        bus.rspError <= err_q;
        bus.rspData  <= (err_q || write_q) ? 32'h0 : load_val;
      end
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LATENCY 0, 1, 3) share one request bus, a
// reference memory model predicts each response, and a scoreboard checks data, error and timing.
module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_width = 2'd0;
  logic        req_uns = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  int          sel = 1;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  logic [2:0]  rdy, rv, rerr;
  logic [31:0] rdat [3];
  logic [31:0] model [3][64];

  typedef struct {
    int          inst;
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : gi
    data_mem_responder_if bus ();
    assign bus.reqValid    = req_valid && (sel == g);
    assign bus.reqWrite    = req_write;
    assign bus.reqWidth    = req_width;
    assign bus.reqUnsigned = req_uns;
    assign bus.reqAddr     = req_addr;
    assign bus.reqWData    = req_wdata;
    assign rdy[g]  = bus.reqReady;
    assign rv[g]   = bus.rspValid;
    assign rerr[g] = bus.rspError;
    assign rdat[g] = bus.rspData;
    data_mem_responder #(.DEPTH(1024), .LATENCY((g == 0) ? 0 : (g == 1) ? 1 : 3)) dut (
      .clk (clk),
      .rstN(rstN),
      .bus (bus)
    );
  end

  function automatic int lat_of(input int inst);
    return (inst == 0) ? 0 : (inst == 1) ? 1 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void model_access(input int inst, input bit wr, input logic [1:0] w,
                                       input bit uns, input logic [31:0] a, input logic [31:0] d,
                                       output logic err, output logic [31:0] data);
    int          wi, sh;
    logic [31:0] wd;
    logic [7:0]  b;
    logic [15:0] h;
    err  = (w == 2'd0) || (w == 2'd2 && a[0]) || (w == 2'd3 && a[1:0] != 2'b00) ||
           (a[31:2] >= 30'd1024) || (a[31:2] >= 30'd64);
    data = 32'h0;
    if (err) return;
    wi = int'(a[7:2]);
    sh = 8 * int'(a[1:0]);
    wd = model[inst][wi];
    b  = wd[sh +: 8];
    h  = a[1] ? wd[31:16] : wd[15:0];
    if (wr) begin
      case (w)
        2'd1: wd[sh +: 8] = d[7:0];
        2'd2: if (a[1]) wd[31:16] = d[15:0]; else wd[15:0] = d[15:0];
        default: wd = d;
      endcase
      model[inst][wi] = wd;
    end else begin
      case (w)
        2'd1: data = uns ? {24'h0, b} : {{24{b[7]}}, b};
        2'd2: data = uns ? {16'h0, h} : {{16{h[15]}}, h};
        default: data = wd;
      endcase
    end
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rv[k]) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 32'(k), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_inst", 32'(k), 32'(e.inst));
          check("rsp_data", rdat[k], e.data);
          check("rsp_error", {31'h0, rerr[k]}, {31'h0, e.err});
          check("rsp_cycle", 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'h0);
      sb.delete();
    end
  endtask

  task automatic issue(input int inst, input bit wr, input logic [1:0] w, input bit uns,
                       input logic [31:0] a, input logic [31:0] d, input bit hold, input bit track);
    int          t, n;
    logic        e_err;
    logic [31:0] e_data;
    drain();
    @(negedge clk);
    t = 0;
    while (!rdy[inst] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rdy[inst]) check("ready_timeout", {31'h0, rdy[inst]}, 32'h1);
    sel       = inst;
    req_write = wr;
    req_width = w;
    req_uns   = uns;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    if (!hold) req_valid = 1'b0;
    if (track) begin
      model_access(inst, wr, w, uns, a, d, e_err, e_data);
      sb.push_back('{inst, e_data, e_err, n + lat_of(inst) + 1});
    end
    if (hold) begin
      @(negedge clk);
      t = 0;
      while (!rdy[inst] && t < 20) begin
        @(negedge clk);
        t++;
      end
      check("ready_return_cycle", 32'(cyc), 32'(n + lat_of(inst) + 2));
      req_valid = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_ready", {31'h0, rdy[k]}, 32'h1);
      check("rst_rspvalid", {31'h0, rv[k]}, 32'h0);
      check("rst_rspdata", rdat[k], 32'h0);
      check("rst_rsperror", {31'h0, rerr[k]}, 32'h0);
    end
    rstN = 1'b1;
    @(negedge clk);
    check("idle_ready", {31'h0, rdy[1]}, 32'h1);
    check("idle_rspvalid", {31'h0, rv[1]}, 32'h0);

    // LATENCY=1: stores, lane steering, extension
    issue(1, 1, 2'd3, 0, 32'h10, 32'hDEADBEEF, 0, 1);
    issue(1, 1, 2'd1, 0, 32'h11, 32'h000000A5, 0, 1);
    issue(1, 0, 2'd3, 0, 32'h10, 32'h0, 0, 1);
    issue(1, 0, 2'd1, 0, 32'h11, 32'h0, 0, 1);
    issue(1, 0, 2'd1, 1, 32'h11, 32'h0, 0, 1);
    issue(1, 1, 2'd3, 0, 32'h20, 32'h11223344, 0, 1);
    issue(1, 1, 2'd2, 0, 32'h22, 32'h00008001, 0, 1);
    issue(1, 0, 2'd2, 0, 32'h22, 32'h0, 0, 1);
    issue(1, 0, 2'd2, 1, 32'h22, 32'h0, 0, 1);
    issue(1, 0, 2'd3, 0, 32'h20, 32'h0, 0, 1);
    issue(1, 1, 2'd1, 0, 32'h23, 32'h0000007E, 0, 1);
    issue(1, 0, 2'd1, 0, 32'h23, 32'h0, 0, 1);
    issue(1, 0, 2'd3, 0, 32'h20, 32'h0, 0, 1);

    // Error cases
    issue(1, 0, 2'd3, 0, 32'h13, 32'h0, 0, 1);
    issue(1, 1, 2'd2, 0, 32'h11, 32'h0000FFFF, 0, 1);
    issue(1, 0, 2'd3, 0, 32'h10, 32'h0, 0, 1);
    issue(1, 0, 2'd0, 0, 32'h10, 32'h0, 0, 1);
    issue(1, 0, 2'd3, 0, 32'h1000, 32'h0, 0, 1);
    issue(1, 1, 2'd1, 0, 32'h1000, 32'h55, 0, 1);
    issue(1, 0, 2'd2, 0, 32'h12, 32'h0, 0, 1);

    // Other latencies
    issue(0, 1, 2'd3, 0, 32'h40, 32'hA5A50F0F, 0, 1);
    issue(0, 0, 2'd2, 1, 32'h42, 32'h0, 0, 1);
    issue(0, 0, 2'd3, 0, 32'h41, 32'h0, 0, 1);
    issue(2, 1, 2'd3, 0, 32'h40, 32'h01020304, 0, 1);
    issue(2, 0, 2'd1, 0, 32'h43, 32'h0, 0, 1);

    // reqValid held through WAIT/RESP: one response, ready only back in IDLE
    issue(1, 0, 2'd3, 0, 32'h10, 32'h0, 1, 1);
    issue(2, 0, 2'd3, 0, 32'h40, 32'h0, 1, 1);
    issue(0, 0, 2'd1, 1, 32'h40, 32'h0, 1, 1);

    // Reset in the middle of WAIT drops the store
    issue(2, 1, 2'd3, 0, 32'h30, 32'hCAFEF00D, 0, 1);
    issue(2, 1, 2'd3, 0, 32'h30, 32'h12345678, 0, 0);
    @(negedge clk);
    rstN = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_rspvalid", {29'h0, rv}, 32'h0);
    rstN = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst_ready", {31'h0, rdy[2]}, 32'h1);
    issue(2, 0, 2'd3, 0, 32'h30, 32'h0, 0, 1);

    drain();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the MEM stage's load/store requests: the target end of the pipeline's data-memory interface.
- Accepts one request at a time over a valid/ready handshake and models a configurable access latency.
- Performs byte/half/word writes with lane steering, and reads with sign/zero extension.
- Returns a one-cycle response pulse carrying load data and an error flag. Storage is an internal word array.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array; word index = reqAddr[31:2].
- LATENCY, 1, extra wait cycles before the array access (0 allowed).

Ports:
- clk  in  1  clock
- rstN  in  1  synchronous, active-low reset
- reqValid  in  1  request present
- reqReady  out  1  responder can accept (= state IDLE)
- reqWrite  in  1  1 = store, 0 = load
- reqWidth  in  2  MemoryAccessWidth: MEM_NONE=0, MEM_BYTE=1, MEM_HALF=2, MEM_WORD=3
- reqUnsigned  in  1  zero-extend load (LBU/LHU); ignored for word loads and for stores
- reqAddr  in  32  MemAddr, byte address
- reqWData  in  32  BasicData store data, right-aligned (byte in [7:0], half in [15:0])
- rspValid  out  1  response pulse, one cycle
- rspData  out  32  load result; 0 for stores and for errors
- rspError  out  1  request rejected, no memory effect

Behaviour:
- Reset: clk and rstN only, sampled on the rising edge.
  - While rstN=0: state=IDLE, rspValid=0, rspData=0, rspError=0, counter=0.
  - Array contents are not reset.
  - Reset mid-operation drops the in-flight request. A store not yet performed leaves memory unchanged.
- States: IDLE, WAIT, RESP.
  - IDLE: reqReady=1. On reqValid=1, latch all req* fields and the computed error, load counter=LATENCY, go to WAIT.
  - WAIT: reqReady=0.
    - If counter!=0: decrement.
    - If counter==0: perform the access unless error, register rspData/rspError, go to RESP.
  - RESP: rspValid=1 for exactly this cycle, reqReady=0, then go to IDLE. rspData/rspError hold their values until the next RESP entry or reset.
- Latency:
  - Request accepted at edge N -> rspValid high in the cycle after edge N+LATENCY+1.
  - The next request can be accepted at edge N+LATENCY+3.
  - Errors take the same latency.
- Error conditions, evaluated at accept (any one sets rspError=1, rspData=0, no write):
  - reqWidth==MEM_NONE.
  - MEM_HALF with addr[0]=1.
  - MEM_WORD with addr[1:0]!=0.
  - addr[31:2] >= DEPTH.
- Store lane steering on word W=mem[addr[31:2]]:
  - BYTE writes W[8*a+7:8*a] with reqWData[7:0], where a=addr[1:0].
  - HALF writes W[16*h+15:16*h] with reqWData[15:0], where h=addr[1].
  - WORD writes all 32 bits.
  - Untouched lanes are preserved.
  - Store response: rspData=0, rspError=0.
- Load extraction:
  - BYTE: selected lane, bit 7 replicated to bits 31:8 when reqUnsigned=0, zeros otherwise.
  - HALF: selected half, same extension rule using bit 15.
  - WORD: raw word.
- Inputs other than reqValid are don't-care outside the IDLE accept edge. reqValid while not IDLE is ignored (not queued).

Test Plan:
- Reset, then hold rstN=1 with LATENCY=1 -> reqReady=1, rspValid=0. SW addr 0x10 data 0xDEADBEEF accepted at edge N -> rspValid=1, rspError=0, rspData=0 in the cycle after edge N+2.
- SB addr 0x11 data 0x000000A5, then LW 0x10 -> rspData=0xDEADA5EF. LB 0x11 -> 0xFFFFFFA5. LBU 0x11 -> 0x000000A5.
- SH addr 0x22 data 0x00008001, then LH 0x22 -> 0xFFFF8001. LHU 0x22 -> 0x00008001. LW 0x20 has bits [15:0] unchanged from the prior value.
- Misaligned: LW 0x13 -> rspError=1, rspData=0. SH 0x11 -> rspError=1, and a subsequent LW 0x10 shows no change. MEM_NONE -> rspError=1. Addr 4*DEPTH -> rspError=1.
- Handshake and latency:
  - With LATENCY=0: response arrives in the cycle after edge N+1.
  - With LATENCY=3: response arrives in the cycle after edge N+4.
  - reqValid held high during WAIT/RESP -> exactly one response per accept, and reqReady reasserts only in IDLE.
- Reset mid-WAIT on SW 0x30 data 0x12345678 (LATENCY=3, rstN=0 at edge N+1) -> rspValid never asserts. A later LW 0x30 returns the old contents.
